// File: rtl/sprite_pkg.sv
// Shared definitions for the scanline sprite engine: attribute word layout,
// evaluation FSM states and the per-slot record.
package sprite_pkg;

  localparam int unsigned ATTR_Y_LSB    = 0;
  localparam int unsigned ATTR_Y_W      = 10;
  localparam int unsigned ATTR_X_LSB    = 10;
  localparam int unsigned ATTR_X_W      = 10;
  localparam int unsigned ATTR_PAT_LSB  = 20;
  localparam int unsigned ATTR_PAT_W    = 7;
  localparam int unsigned ATTR_FLIP_BIT = 27;
  localparam int unsigned ATTR_PAL_LSB  = 28;
  localparam int unsigned ATTR_PAL_W    = 4;

  // slot_t is sized for the default 32-bit pattern row.
  localparam int unsigned SLOT_PAT_W    = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_A_REQ,
    S_A_CHK,
    S_P_REQ,
    S_P_LOAD,
    S_DONE
  } eval_state_t;

  typedef struct packed {
    logic                  valid;
    logic [ATTR_X_W-1:0]   x;
    logic [ATTR_PAL_W-1:0] palette;
    logic [SLOT_PAT_W-1:0] row;
  } slot_t;

endpackage

// File: rtl/sprite_line_engine_if.sv
// Video timing, attribute/pattern memory ports and pixel outputs of the sprite engine.
// master = engine side, slave = timing generator, memories and colour table.
interface sprite_line_engine_if #(
  parameter int AW    = 6,
  parameter int PAT_W = 32,
  parameter int PAL_W = 4,
  parameter int BPP   = 2
);
  logic [10:0]          hcount;
  logic [9:0]           vcount;
  logic [AW-1:0]        attr_addr;
  logic [31:0]          attr_data;
  logic [9:0]           pat_addr;
  logic [PAT_W-1:0]     pat_data;
  logic [PAL_W+BPP-1:0] pix_color;
  logic                 pix_opaque;
  logic                 line_overflow;
  logic                 eval_timeout;
  logic                 eval_busy;

  modport master (
    input  hcount, vcount, attr_data, pat_data,
    output attr_addr, pat_addr, pix_color, pix_opaque,
           line_overflow, eval_timeout, eval_busy
  );

  modport slave (
    output hcount, vcount, attr_data, pat_data,
    input  attr_addr, pat_addr, pix_color, pix_opaque,
           line_overflow, eval_timeout, eval_busy
  );
endinterface

// File: rtl/sprite_slot.sv
// One sprite slot: holds position, palette and pattern row (flipped on load)
// and reports whether it covers the current pixel column and its pixel value.
module sprite_slot
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = 16,
  parameter int BPP      = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic [ATTR_X_W-1:0]   i_x,
  input  logic [ATTR_PAL_W-1:0] i_palette,
  input  logic                  i_hflip,
  input  logic [SLOT_PAT_W-1:0] i_pat,
  input  logic [9:0]            i_px,
  output logic                  o_covered,
  output logic [ATTR_PAL_W-1:0] o_palette,
  output logic [BPP-1:0]        o_pix
);
  localparam int IDX_W = $clog2(SPRITE_W);

  slot_t                 r_slot;
  logic [SLOT_PAT_W-1:0] w_flipped;
  logic [ATTR_X_W-1:0]   w_off;

  always_comb begin
    w_flipped = '0;
    for (int i = 0; i < SPRITE_W; i++) begin
      w_flipped[i*BPP +: BPP] = i_pat[(SPRITE_W-1-i)*BPP +: BPP];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_slot <= '0;
    end else if (i_load) begin
      r_slot.valid   <= 1'b1;
      r_slot.x       <= i_x;
      r_slot.palette <= i_palette;
      r_slot.row     <= i_hflip ? w_flipped : i_pat;
    end
  end

  // No horizontal wrap: columns left of x are never covered.
  assign w_off     = i_px - r_slot.x;
  assign o_covered = r_slot.valid && (i_px >= r_slot.x) && (w_off < 10'(SPRITE_W));
  assign o_palette = r_slot.palette;
  assign o_pix     = r_slot.row[w_off[IDX_W-1:0]*BPP +: BPP];

endmodule

// File: rtl/sprite_line_engine.sv
// Scanline sprite engine: evaluates the next line's sprites during horizontal blank
// and emits a prioritised per-pixel palette index during active video.
//   state  | meaning
//   IDLE   | waiting for start of horizontal blank
//   A_REQ  | attribute read issued
//   A_CHK  | attribute word valid, hit test
//   P_REQ  | pattern read issued
//   P_LOAD | pattern row valid, slot loaded
//   DONE   | evaluation finished, waiting for end of line
module sprite_line_engine
  import sprite_pkg::*;
#(
  parameter int MAX_SPRITES = 8,
  parameter int NUM_ATTRS   = 64,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int BPP         = 2,
  parameter int PAT_W       = SLOT_PAT_W,
  parameter int PAL_W       = ATTR_PAL_W,
  parameter int HACTIVE     = 1280,
  parameter int HTOTAL      = 1600,
  parameter int VTOTAL      = 525
) (
  input logic                  i_clk,
  input logic                  i_reset,
  sprite_line_engine_if.master bus
);
  localparam int AW = $clog2(NUM_ATTRS);
  localparam int VW = $clog2(MAX_SPRITES + 1);

  eval_state_t           r_state, w_state_nxt;
  logic [AW-1:0]         r_ac;
  logic [VW-1:0]         r_vc;
  logic [9:0]            r_pat_addr;
  logic [ATTR_X_W-1:0]   r_x;
  logic [ATTR_PAL_W-1:0] r_pal;
  logic                  r_flip;
  logic                  r_line_overflow, r_eval_timeout;
  logic [PAL_W+BPP-1:0]  r_pix_color;
  logic                  r_pix_opaque;

  logic [9:0]            w_ty, w_row, w_pat_addr, w_px;
  logic                  w_hit, w_last, w_active;
  logic                  w_start, w_take, w_adv, w_load, w_ovf_set, w_to_set;
  logic [PAT_W-1:0]      w_pat;
  logic                  w_cov [MAX_SPRITES];
  logic [PAL_W-1:0]      w_pal [MAX_SPRITES];
  logic [BPP-1:0]        w_pix [MAX_SPRITES];
  logic                  w_found;
  logic [PAL_W+BPP-1:0]  w_color;

  assign w_ty       = (bus.vcount == 10'(VTOTAL - 1)) ? 10'd0 : bus.vcount + 10'd1;
  assign w_row      = w_ty - bus.attr_data[ATTR_Y_LSB +: ATTR_Y_W];
  assign w_hit      = (w_row < 10'(SPRITE_H));
  assign w_last     = &r_ac;
  assign w_pat_addr = 10'(bus.attr_data[ATTR_PAT_LSB +: ATTR_PAT_W] * SPRITE_H) + w_row;
  assign w_active   = (r_state != S_IDLE) && (r_state != S_DONE);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_take      = 1'b0;
    w_adv       = 1'b0;
    w_load      = 1'b0;
    w_ovf_set   = 1'b0;
    w_to_set    = 1'b0;
    case (r_state)
      S_IDLE: if (bus.hcount == 11'(HACTIVE)) begin
        w_start     = 1'b1;
        w_state_nxt = S_A_REQ;
      end
      S_A_REQ: w_state_nxt = S_A_CHK;
      S_A_CHK: begin
        if (w_hit && (r_vc == VW'(MAX_SPRITES))) begin
          w_ovf_set   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_hit) begin
          w_take      = 1'b1;
          w_state_nxt = S_P_REQ;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_adv       = 1'b1;
          w_state_nxt = S_A_REQ;
        end
      end
      S_P_REQ: w_state_nxt = S_P_LOAD;
      S_P_LOAD: begin
        w_load = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_adv       = 1'b1;
          w_state_nxt = S_A_REQ;
        end
      end
      S_DONE: if (bus.hcount == 11'(HTOTAL - 1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // End of blank cuts the scan short; a row already on the bus still lands.
    if (w_active && (bus.hcount == 11'(HTOTAL - 2))) begin
      w_to_set    = 1'b1;
      w_take      = 1'b0;
      w_adv       = 1'b0;
      w_state_nxt = S_DONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ac            <= '0;
      r_vc            <= '0;
      r_pat_addr      <= '0;
      r_x             <= '0;
      r_pal           <= '0;
      r_flip          <= 1'b0;
      r_line_overflow <= 1'b0;
      r_eval_timeout  <= 1'b0;
    end else begin
      if (w_start) begin
        r_ac            <= '0;
        r_vc            <= '0;
        r_line_overflow <= 1'b0;
        r_eval_timeout  <= 1'b0;
      end
      if (w_ovf_set) r_line_overflow <= 1'b1;
      if (w_to_set)  r_eval_timeout  <= 1'b1;
      if (w_take) begin
        r_x        <= bus.attr_data[ATTR_X_LSB +: ATTR_X_W];
        r_pal      <= bus.attr_data[ATTR_PAL_LSB +: ATTR_PAL_W];
        r_flip     <= bus.attr_data[ATTR_FLIP_BIT];
        r_pat_addr <= w_pat_addr;
      end
      if (w_adv)  r_ac <= r_ac + 1'b1;
      if (w_load) r_vc <= r_vc + 1'b1;
    end
  end

  assign w_pat = bus.pat_data;
  assign w_px  = bus.hcount[10:1];

  for (genvar g = 0; g < MAX_SPRITES; g++) begin : g_slot
    sprite_slot #(.SPRITE_W(SPRITE_W), .BPP(BPP)) u_slot (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clear   (w_start),
      .i_load    (w_load && (r_vc == VW'(g))),
      .i_x       (r_x),
      .i_palette (r_pal),
      .i_hflip   (r_flip),
      .i_pat     (w_pat),
      .i_px      (w_px),
      .o_covered (w_cov[g]),
      .o_palette (w_pal[g]),
      .o_pix     (w_pix[g])
    );
  end

  // Scan from the highest slot down so the lowest opaque slot is the last writer.
  always_comb begin
    w_found = 1'b0;
    w_color = '0;
    for (int k = MAX_SPRITES - 1; k >= 0; k--) begin
      if (w_cov[k] && (w_pix[k] != '0)) begin
        w_found = 1'b1;
        w_color = {w_pal[k], w_pix[k]};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pix_color  <= '0;
      r_pix_opaque <= 1'b0;
    end else if ((bus.hcount < 11'(HACTIVE)) && w_found) begin
      r_pix_color  <= w_color;
      r_pix_opaque <= 1'b1;
    end else begin
      r_pix_color  <= '0;
      r_pix_opaque <= 1'b0;
    end
  end

  assign bus.attr_addr     = r_ac;
  assign bus.pat_addr      = r_pat_addr;
  assign bus.pix_color     = r_pix_color;
  assign bus.pix_opaque    = r_pix_opaque;
  assign bus.line_overflow = r_line_overflow;
  assign bus.eval_timeout  = r_eval_timeout;
  assign bus.eval_busy     = w_active;

endmodule
